branch_stat_regs: RTL and testbench

//  Consumes the per-cycle branch event pulses from the BTB: branch in EX, BTB hit, misprediction.

---
 rtl/branch_stat_pkg.sv | 29 ++
 rtl/branch_stat_regs_sat_counter.sv | 47 ++++
 rtl/branch_stat_regs.sv | 90 +++++++++
 tb/tb_branch_stat_regs.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_stat_pkg.sv
// Shared register map, CTRL layout and helpers for the branch statistics block.
package branch_stat_pkg;

  localparam logic [2:0] BR_LO  = 3'd0;
  localparam logic [2:0] BR_HI  = 3'd1;
  localparam logic [2:0] HIT_LO = 3'd2;
  localparam logic [2:0] HIT_HI = 3'd3;
  localparam logic [2:0] MSP_LO = 3'd4;
  localparam logic [2:0] MSP_HI = 3'd5;
  localparam logic [2:0] CTRL   = 3'd6;
  localparam logic [2:0] RSVD   = 3'd7;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;
  localparam int CTRL_SAT_BIT = 2;

  // First member is the MSB, so en lands on bit 0 and sat_any on bit 2.
  typedef struct packed {
    logic sat_any;
    logic clr;
    logic en;
  } ctrl_t;

  // CTRL as software sees it on the 16-bit bus.
  function automatic logic [15:0] ctrl_to_word(input ctrl_t c);
    return {13'd0, c};
  endfunction

endpackage

// File: rtl/branch_stat_regs_sat_counter.sv
// Saturating event counter with a shadow of its upper bits for tear-free LO/HI reads.
module sat_counter
  import branch_stat_pkg::*;
#(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          snap,
  output logic [15:0]   lo,
  output logic [W-17:0] hi_shadow,
  output logic          sat
);

  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-17:0] shadow_q, shadow_d;

  assign sat       = &cnt_q;
  assign lo        = cnt_q[15:0];
  assign hi_shadow = shadow_q;

  // Next state: shadow captures the pre-increment upper bits; clear overrides everything.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (snap) shadow_d = cnt_q[W-1:16];
    if (inc && !sat) cnt_d = cnt_q + W'(1);
    if (clr) begin
      cnt_d    = '0;
      shadow_d = '0;
    end
  end

  // Counter and shadow registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/branch_stat_regs.sv
// Memory-mapped branch statistics: three saturating counters plus a CTRL register.
module branch_stat_regs
  import branch_stat_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter bit ENABLE_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt,
  input  logic [2:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        rd_valid
);

  logic        en_q, en_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q;
  logic        wr_ctrl, clr;
  ctrl_t       ctrl;

  logic [15:0]      br_lo, hit_lo, msp_lo;
  logic [CNT_W-17:0] br_hi, hit_hi, msp_hi;
  logic             br_sat, hit_sat, msp_sat;

  // Only bits 1:0 of a write carry meaning.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[15:2];

  assign wr_ctrl = we && (addr == CTRL);
  assign clr     = wr_ctrl && wr_data[CTRL_CLR_BIT];
  assign en_d    = wr_ctrl ? wr_data[CTRL_EN_BIT] : en_q;

  sat_counter #(.W(CNT_W)) u_br (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(en_q && inc_br_cnt),
    .snap(re && (addr == BR_LO)), .lo(br_lo), .hi_shadow(br_hi), .sat(br_sat)
  );

  sat_counter #(.W(CNT_W)) u_hit (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(en_q && inc_hit_cnt),
    .snap(re && (addr == HIT_LO)), .lo(hit_lo), .hi_shadow(hit_hi), .sat(hit_sat)
  );

  sat_counter #(.W(CNT_W)) u_msp (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(en_q && inc_mispr_cnt),
    .snap(re && (addr == MSP_LO)), .lo(msp_lo), .hi_shadow(msp_hi), .sat(msp_sat)
  );

  // Read mux over pre-write state; rd_data holds between reads.
  always_comb begin
    ctrl.en      = en_q;
    ctrl.clr     = 1'b0;
    ctrl.sat_any = br_sat | hit_sat | msp_sat;
    rd_data_d    = rd_data_q;
    if (re) begin
      case (addr)
        BR_LO:   rd_data_d = br_lo;
        BR_HI:   rd_data_d = 16'(br_hi);
        HIT_LO:  rd_data_d = hit_lo;
        HIT_HI:  rd_data_d = 16'(hit_hi);
        MSP_LO:  rd_data_d = msp_lo;
        MSP_HI:  rd_data_d = 16'(msp_hi);
        CTRL:    rd_data_d = ctrl_to_word(ctrl);
        default: rd_data_d = 16'd0;
      endcase
    end
  end

  // CTRL enable bit and registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q       <= ENABLE_RST;
      rd_data_q  <= 16'd0;
      rd_valid_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= re;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_branch_stat_regs.sv
// Randomised and directed bench for branch_stat_regs with a queue-based scoreboard.
module tb_branch_stat_regs;

  localparam int CNT_W = 17;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc_br_cnt = 1'b0, inc_hit_cnt = 1'b0, inc_mispr_cnt = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic        re = 1'b0, we = 1'b0;
  logic [15:0] wr_data = 16'd0;
  logic [15:0] rd_data;
  logic        rd_valid;

  branch_stat_regs #(.CNT_W(CNT_W), .ENABLE_RST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt),
    .inc_mispr_cnt(inc_mispr_cnt), .addr(addr), .re(re), .we(we),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: counts as plain integers, shadows as the count divided by 65536.
  int          m_cnt[3];
  int          m_sh[3];
  bit          m_en;
  logic [15:0] expq[$];
  logic [CNT_W-1:0] pre_val;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_sh[k]  = 0;
    end
    m_en = 1'b1;
  endfunction

  function automatic void model_step(input logic [2:0] inc, input logic r, input logic [2:0] a,
                                     input logic w, input logic [15:0] wd);
    logic [15:0] v;
    bit          sat_any;
    bit          c;
    int          k;
    k = int'(a) / 2;
    sat_any = (m_cnt[0] == MAXV) || (m_cnt[1] == MAXV) || (m_cnt[2] == MAXV);
    if (r) begin
      if (a < 3'd6) v = a[0] ? 16'(m_sh[k]) : 16'(m_cnt[k] % 65536);
      else if (a == 3'd6) v = {13'd0, sat_any, 1'b0, m_en};
      else v = 16'd0;
      expq.push_back(v);
      if (a < 3'd6 && !a[0]) m_sh[k] = m_cnt[k] / 65536;
    end
    c = w && (a == 3'd6) && wd[1];
    for (int j = 0; j < 3; j++) begin
      if (c) begin
        m_cnt[j] = 0;
        m_sh[j]  = 0;
      end else if (m_en && inc[j] && m_cnt[j] < MAXV) begin
        m_cnt[j] = m_cnt[j] + 1;
      end
    end
    if (w && a == 3'd6) m_en = wd[0];
  endfunction

  task automatic cyc(input logic [2:0] inc, input logic r, input logic [2:0] a,
                     input logic w, input logic [15:0] wd);
    @(negedge clk);
    inc_br_cnt = inc[0]; inc_hit_cnt = inc[1]; inc_mispr_cnt = inc[2];
    re = r; addr = a; we = w; wr_data = wd;
    model_step(inc, r, a, w, wd);
  endtask

  task automatic idle();
    cyc(3'b000, 1'b0, 3'd0, 1'b0, 16'd0);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(3'b000, 1'b1, a, 1'b0, 16'd0);
  endtask

  task automatic wr_ctrl(input logic [15:0] wd);
    cyc(3'b000, 1'b0, 3'd6, 1'b1, wd);
  endtask

  // Loads a counter directly so long count sequences stay short.
  task automatic preload(input int k, input logic [CNT_W-1:0] val);
    @(negedge clk);
    inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0; re = 0; we = 0;
    pre_val = val;
    case (k)
      0: force dut.u_br.cnt_q = pre_val;
      1: force dut.u_hit.cnt_q = pre_val;
      default: force dut.u_msp.cnt_q = pre_val;
    endcase
    @(negedge clk);
    case (k)
      0: release dut.u_br.cnt_q;
      1: release dut.u_hit.cnt_q;
      default: release dut.u_msp.cnt_q;
    endcase
    m_cnt[k] = int'(val);
  endtask

  // Monitor: after each posedge, compare the read port against the scoreboard.
  logic [15:0] last_data = 16'd0;
  initial begin
    logic exp_v, was_rst;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      exp_v   = re && rst_n;
      was_rst = !rst_n;
      #1;
      if (was_rst) begin
        last_data = 16'd0;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
      end else if (exp_v || rd_valid) begin
        chk("rd_valid", int'(rd_valid), int'(exp_v));
        if (expq.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          e = expq.pop_front();
          chk("rd_data", int'(rd_data), int'(e));
          last_data = e;
        end
      end else begin
        chk("rd_data_hold", int'(rd_data), int'(last_data));
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset values on every address.
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle();

    // Five branch pulses.
    repeat (5) cyc(3'b001, 1'b0, 3'd0, 1'b0, 16'd0);
    rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd4); rd(3'd5);
    idle();

    // Clear beats a same-cycle increment.
    repeat (7) cyc(3'b100, 1'b0, 3'd0, 1'b0, 16'd0);
    rd(3'd4);
    cyc(3'b100, 1'b0, 3'd6, 1'b1, 16'h0003);
    rd(3'd4); rd(3'd6);
    idle();

    // Tear-free LO/HI across the 16-bit boundary.
    preload(0, 17'h0FFFF);
    cyc(3'b001, 1'b1, 3'd0, 1'b0, 16'd0);
    rd(3'd1); rd(3'd0); rd(3'd1);
    idle();

    // Crossing into the upper half, then saturation.
    preload(1, 17'h0FFFF);
    cyc(3'b010, 1'b0, 3'd0, 1'b0, 16'd0);
    rd(3'd2); rd(3'd3);
    repeat (65535) cyc(3'b010, 1'b0, 3'd0, 1'b0, 16'd0);
    rd(3'd2); rd(3'd3); rd(3'd6);
    cyc(3'b010, 1'b0, 3'd0, 1'b0, 16'd0);
    rd(3'd2); rd(3'd3); rd(3'd6);
    idle();

    // Randomised traffic, including writes to counter addresses and read+write collisions.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] wd;
      wd = 16'($urandom);
      if ($urandom_range(0, 7) != 0) wd[1] = 1'b0;
      if ($urandom_range(0, 2) != 0) wd[0] = 1'b1;
      cyc(3'($urandom), 1'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0), wd);
    end
    idle();

    // Disabled counting, then reset in the middle of a read.
    wr_ctrl(16'h0000);
    for (int a = 0; a < 7; a++) rd(3'(a));
    repeat (10) cyc(3'b111, 1'b0, 3'd0, 1'b0, 16'd0);
    for (int a = 0; a < 7; a++) rd(3'(a));
    idle();
    @(negedge clk);
    inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0; we = 0;
    re = 1'b1; addr = 3'd0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    re = 1'b0; rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a));
    repeat (3) idle();

    chk("scoreboard_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
